// File: rtl/dmem_arbiter.sv
// Purpose: arbitrates core and DMA load/store requests onto one data-memory port,
//          with a starvation limit that forces a DMA grant after STARVE_LIMIT core grants.
// Latency: grant is combinational in the request cycle; read data returns one cycle after grant.
// Backpressure: dm_ready_in low holds the presented owner (HOLD_CORE/HOLD_DMA) until accepted
//               or withdrawn.
// Ports:
//   clk_in, rst_in                      clock, synchronous active-high reset
//   core_* / dma_* (req, wr, addr,
//       wdata, mask in; gnt, rvalid,
//       rdata out)                      requester ports; rdata mirrors dmdata_in, qualified by rvalid
//   dmaddr_out, dmdata_out,
//       dmwr_mask_out, dmwr_req_out,
//       dmrd_req_out                    memory request, mirrors the current owner
//   dm_ready_in, dmdata_in              memory acceptance and read data
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        core_req_in,
    input  logic        core_wr_in,
    input  logic [31:0] core_addr_in,
    input  logic [31:0] core_wdata_in,
    input  logic [3:0]  core_mask_in,
    output logic        core_gnt_out,
    output logic        core_rvalid_out,
    output logic [31:0] core_rdata_out,
    input  logic        dma_req_in,
    input  logic        dma_wr_in,
    input  logic [31:0] dma_addr_in,
    input  logic [31:0] dma_wdata_in,
    input  logic [3:0]  dma_mask_in,
    output logic        dma_gnt_out,
    output logic        dma_rvalid_out,
    output logic [31:0] dma_rdata_out,
    output logic [31:0] dmaddr_out,
    output logic [31:0] dmdata_out,
    output logic [3:0]  dmwr_mask_out,
    output logic        dmwr_req_out,
    output logic        dmrd_req_out,
    input  logic        dm_ready_in,
    input  logic [31:0] dmdata_in
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, HOLD_CORE, HOLD_DMA} state_t;

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        rd_pending_q, rd_pending_d;
    logic        rd_owner_q, rd_owner_d;   // 1 = DMA owns the pending read
    logic        own_core, own_dma;
    logic        own_req, own_wr;

    // Owner selection. Reset masks ownership so every output stays quiet while rst_in is high.
    always_comb begin
        own_core = 1'b0;
        own_dma  = 1'b0;
        if (!rst_in) begin
            case (state_q)
                HOLD_CORE: own_core = 1'b1;
                HOLD_DMA:  own_dma  = 1'b1;
                default: begin
                    if (core_req_in && dma_req_in) begin
                        if (starve_q == LIMIT) own_dma  = 1'b1;
                        else                   own_core = 1'b1;
                    end else if (core_req_in) begin
                        own_core = 1'b1;
                    end else if (dma_req_in) begin
                        own_dma = 1'b1;
                    end
                end
            endcase
        end
    end

    // Memory side mirrors whichever port owns it; all zero with no owner.
    always_comb begin
        own_req       = 1'b0;
        own_wr        = 1'b0;
        dmaddr_out    = '0;
        dmdata_out    = '0;
        dmwr_mask_out = '0;
        if (own_core) begin
            own_req       = core_req_in;
            own_wr        = core_wr_in;
            dmaddr_out    = core_addr_in;
            dmdata_out    = core_wdata_in;
            dmwr_mask_out = core_mask_in;
        end else if (own_dma) begin
            own_req       = dma_req_in;
            own_wr        = dma_wr_in;
            dmaddr_out    = dma_addr_in;
            dmdata_out    = dma_wdata_in;
            dmwr_mask_out = dma_mask_in;
        end
    end

    assign dmwr_req_out = own_req & own_wr;
    assign dmrd_req_out = own_req & ~own_wr;
    assign core_gnt_out = own_core & core_req_in & dm_ready_in;
    assign dma_gnt_out  = own_dma & dma_req_in & dm_ready_in;

    // Read return: rdata is a plain wire from memory; rvalid is the only qualifier.
    // A pending return is dropped if reset lands in the return cycle.
    assign core_rdata_out  = dmdata_in;
    assign dma_rdata_out   = dmdata_in;
    assign core_rvalid_out = rd_pending_q & ~rd_owner_q & ~rst_in;
    assign dma_rvalid_out  = rd_pending_q & rd_owner_q & ~rst_in;

    always_comb begin
        // Stalled owner is locked in; accepted or withdrawn request goes back to IDLE.
        state_d = IDLE;
        if (own_req && !dm_ready_in) begin
            state_d = own_core ? HOLD_CORE : HOLD_DMA;
        end

        starve_d = starve_q;
        if (!dma_req_in || dma_gnt_out) begin
            starve_d = '0;
        end else if (core_gnt_out && starve_q != LIMIT) begin
            starve_d = starve_q + 4'd1;
        end

        rd_pending_d = (core_gnt_out & ~core_wr_in) | (dma_gnt_out & ~dma_wr_in);
        rd_owner_d   = dma_gnt_out;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        core_req_in = 0, core_wr_in = 0;
    logic [31:0] core_addr_in = 0, core_wdata_in = 0;
    logic [3:0]  core_mask_in = 0;
    logic        dma_req_in = 0, dma_wr_in = 0;
    logic [31:0] dma_addr_in = 0, dma_wdata_in = 0;
    logic [3:0]  dma_mask_in = 0;
    logic        dm_ready_in = 0;
    logic [31:0] dmdata_in = 0;
    logic        core_gnt_out, core_rvalid_out, dma_gnt_out, dma_rvalid_out;
    logic [31:0] core_rdata_out, dma_rdata_out, dmaddr_out, dmdata_out;
    logic [3:0]  dmwr_mask_out;
    logic        dmwr_req_out, dmrd_req_out;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .core_req_in(core_req_in), .core_wr_in(core_wr_in), .core_addr_in(core_addr_in),
        .core_wdata_in(core_wdata_in), .core_mask_in(core_mask_in),
        .core_gnt_out(core_gnt_out), .core_rvalid_out(core_rvalid_out),
        .core_rdata_out(core_rdata_out),
        .dma_req_in(dma_req_in), .dma_wr_in(dma_wr_in), .dma_addr_in(dma_addr_in),
        .dma_wdata_in(dma_wdata_in), .dma_mask_in(dma_mask_in),
        .dma_gnt_out(dma_gnt_out), .dma_rvalid_out(dma_rvalid_out),
        .dma_rdata_out(dma_rdata_out),
        .dmaddr_out(dmaddr_out), .dmdata_out(dmdata_out), .dmwr_mask_out(dmwr_mask_out),
        .dmwr_req_out(dmwr_req_out), .dmrd_req_out(dmrd_req_out),
        .dm_ready_in(dm_ready_in), .dmdata_in(dmdata_in)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    // Reference model: who has a stalled access locked in (0 none, 1 core, 2 DMA),
    // how many core grants DMA has sat through, and any read awaiting return.
    int m_lock = 0;
    int m_streak = 0;
    bit m_rpend = 0;
    int m_rown = 0;
    bit m_cg = 0, m_dg = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk_in);
        #1;
    endtask

    // Compare every DUT output against the model at the stable point of the cycle,
    // then advance the model to the state after the coming clock edge.
    task automatic step();
        int own;
        logic oreq, owr, cg, dg;
        logic [31:0] e_addr, e_data;
        logic [3:0] e_mask;
        @(negedge clk_in);
        if (rst_in)                          own = 0;
        else if (m_lock != 0)                own = m_lock;
        else if (core_req_in && dma_req_in)  own = (m_streak == LIMIT) ? 2 : 1;
        else if (core_req_in)                own = 1;
        else if (dma_req_in)                 own = 2;
        else                                 own = 0;
        oreq   = (own == 1) ? core_req_in   : (own == 2) ? dma_req_in   : 1'b0;
        owr    = (own == 1) ? core_wr_in    : (own == 2) ? dma_wr_in    : 1'b0;
        e_addr = (own == 1) ? core_addr_in  : (own == 2) ? dma_addr_in  : 32'd0;
        e_data = (own == 1) ? core_wdata_in : (own == 2) ? dma_wdata_in : 32'd0;
        e_mask = (own == 1) ? core_mask_in  : (own == 2) ? dma_mask_in  : 4'd0;
        cg = (own == 1) && core_req_in && dm_ready_in;
        dg = (own == 2) && dma_req_in && dm_ready_in;

        chk("core_gnt", core_gnt_out, cg);
        chk("dma_gnt", dma_gnt_out, dg);
        chk("core_rvalid", core_rvalid_out, !rst_in && m_rpend && m_rown == 1);
        chk("dma_rvalid", dma_rvalid_out, !rst_in && m_rpend && m_rown == 2);
        chk("core_rdata", core_rdata_out, dmdata_in);
        chk("dma_rdata", dma_rdata_out, dmdata_in);
        chk("dmaddr", dmaddr_out, e_addr);
        chk("dmdata", dmdata_out, e_data);
        chk("dmwr_mask", dmwr_mask_out, e_mask);
        chk("dmwr_req", dmwr_req_out, oreq && owr);
        chk("dmrd_req", dmrd_req_out, oreq && !owr);

        if (rst_in) begin
            m_lock = 0; m_streak = 0; m_rpend = 0;
        end else begin
            m_lock  = (own != 0 && oreq && !dm_ready_in) ? own : 0;
            m_rpend = (cg || dg) && !owr;
            m_rown  = own;
            if (!dma_req_in || dg)  m_streak = 0;
            else if (cg)            m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
        end
        m_cg = cg;
        m_dg = dg;
    endtask

    task automatic idle_inputs();
        core_req_in = 0; dma_req_in = 0; core_wr_in = 0; dma_wr_in = 0;
        core_mask_in = 0; dma_mask_in = 0; dm_ready_in = 0;
        core_addr_in = 0; dma_addr_in = 0; core_wdata_in = 0; dma_wdata_in = 0;
    endtask

    initial begin
        // Reset: everything quiet.
        repeat (3) begin
            step();
            chk("reset_gnt", {core_gnt_out, dma_gnt_out}, 0);
            chk("reset_strobes", {dmwr_req_out, dmrd_req_out}, 0);
            chk("reset_addr", dmaddr_out, 0);
        end
        edge1(); rst_in = 0; step();
        chk("post_reset_idle", {dmwr_req_out, dmrd_req_out, core_rvalid_out}, 0);

        // Core store accepted same cycle.
        edge1();
        core_req_in = 1; core_wr_in = 1; core_addr_in = 32'h0000_1004;
        core_wdata_in = 32'h00AB_0000; core_mask_in = 4'h4; dm_ready_in = 1;
        step();
        chk("store_gnt", core_gnt_out, 1);
        chk("store_wr", dmwr_req_out, 1);
        chk("store_addr", dmaddr_out, 32'h0000_1004);
        chk("store_data", dmdata_out, 32'h00AB_0000);
        chk("store_mask", dmwr_mask_out, 4'h4);

        // Zero mask store still granted, mask forwarded as zero.
        edge1(); core_mask_in = 4'h0; step();
        chk("zero_mask_gnt", core_gnt_out, 1);
        chk("zero_mask_fwd", dmwr_mask_out, 0);

        // DMA read stalled; late core request must not steal the port.
        edge1(); idle_inputs();
        dma_req_in = 1; dma_addr_in = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) edge1();
            step();
            chk("hold_dma_addr", dmaddr_out, 32'h2000);
            chk("hold_dma_rd", dmrd_req_out, 1);
        end
        edge1(); core_req_in = 1; core_addr_in = 32'h3000; step();
        chk("hold_dma_vs_core", dmaddr_out, 32'h2000);
        chk("hold_dma_no_gnt", {core_gnt_out, dma_gnt_out}, 0);
        edge1(); dm_ready_in = 1; step();
        chk("hold_dma_gnt", {core_gnt_out, dma_gnt_out}, 2'b01);
        edge1(); dma_req_in = 0; dmdata_in = 32'hDEAD_BEEF; step();
        chk("dma_rvalid_after", dma_rvalid_out, 1);
        chk("dma_rdata_after", dma_rdata_out, 32'hDEAD_BEEF);
        edge1(); core_req_in = 0; step();
        chk("core_rvalid_after", core_rvalid_out, 1);

        // Starvation pattern C,C,C,C,D with both always requesting.
        edge1(); idle_inputs(); step();
        for (int i = 0; i < 10; i++) begin
            edge1();
            core_req_in = 1; dma_req_in = 1; core_wr_in = 1; dma_wr_in = 1; dm_ready_in = 1;
            core_addr_in = 32'h100 + i; dma_addr_in = 32'h900 + i;
            step();
            chk("starve_pattern", {dma_gnt_out, core_gnt_out}, (i % 5 == 4) ? 2'b10 : 2'b01);
        end

        // Three back-to-back core reads, each returning one cycle later.
        edge1(); idle_inputs(); step();
        for (int i = 0; i < 4; i++) begin
            edge1();
            core_req_in = (i < 3); core_wr_in = 0; core_addr_in = 32'h40 + 4 * i;
            dm_ready_in = 1; dmdata_in = 32'hA0 + i;
            step();
            chk("b2b_rvalid", core_rvalid_out, (i > 0));
            if (i > 0) chk("b2b_rdata", core_rdata_out, 32'hA0 + i);
            if (i < 3) chk("b2b_gnt", core_gnt_out, 1);
        end

        // Reset right after an accepted read discards the return.
        edge1(); core_req_in = 1; core_wr_in = 0; dm_ready_in = 1; step();
        chk("rst_read_gnt", core_gnt_out, 1);
        edge1(); rst_in = 1; core_req_in = 0; step();
        chk("rst_read_rvalid", core_rvalid_out, 0);
        chk("rst_read_outs", {dmaddr_out, dmrd_req_out, dmwr_req_out}, 0);
        edge1(); rst_in = 0; step();
        chk("rst_read_rvalid_after", core_rvalid_out, 0);

        // Withdrawn core request in HOLD_CORE: no grant, back to IDLE.
        edge1(); idle_inputs();
        core_req_in = 1; core_wr_in = 1; core_addr_in = 32'h44; step();
        chk("withdraw_stall", {core_gnt_out, dmwr_req_out}, 2'b01);
        edge1(); core_req_in = 0; step();
        chk("withdraw_no_gnt", core_gnt_out, 0);
        chk("withdraw_strobes", {dmwr_req_out, dmrd_req_out}, 0);
        edge1(); dma_req_in = 1; dma_wr_in = 1; dma_addr_in = 32'h5000; step();
        chk("withdraw_idle", dmaddr_out, 32'h5000);
        edge1(); dm_ready_in = 1; step();
        edge1(); idle_inputs(); step();

        // Randomized traffic, requests held until granted.
        for (int n = 0; n < 3000; n++) begin
            edge1();
            rst_in = ($urandom_range(0, 299) == 0);
            if (!core_req_in || m_cg) begin
                core_req_in = ($urandom_range(0, 3) != 0);
                core_wr_in = $urandom_range(0, 1);
                core_addr_in = $urandom; core_wdata_in = $urandom;
                core_mask_in = 4'($urandom_range(0, 15));
            end
            if (!dma_req_in || m_dg) begin
                dma_req_in = ($urandom_range(0, 2) != 0);
                dma_wr_in = $urandom_range(0, 1);
                dma_addr_in = $urandom; dma_wdata_in = $urandom;
                dma_mask_in = 4'($urandom_range(0, 15));
            end
            dm_ready_in = ($urandom_range(0, 3) != 0);
            dmdata_in = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive core grants while DMA waits; legal range 1-15.
REQ-002 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 core_req_in  input  1  core load/store request; held stable with its attributes until core_gnt_out.
REQ-005 core_wr_in  input  1  1 = store, 0 = load.
REQ-006 core_addr_in  input  32  byte address from store/load unit.
REQ-007 core_wdata_in  input  32  lane-aligned store data.
REQ-008 core_mask_in  input  4  byte-lane write mask.
REQ-009 core_gnt_out  output  1  core request accepted this cycle.
REQ-010 core_rvalid_out  output  1  core load data valid on core_rdata_out.
REQ-011 core_rdata_out  output  32  load return data.
REQ-012 dma_req_in, dma_wr_in, dma_addr_in[31:0], dma_wdata_in[31:0], dma_mask_in[3:0]  input  DMA port, same semantics as core port.
REQ-013 dma_gnt_out, dma_rvalid_out, dma_rdata_out[31:0]  output  DMA port, same semantics as core port.
REQ-014 dmaddr_out  output  32  memory address.
REQ-015 dmdata_out  output  32  memory write data.
REQ-016 dmwr_mask_out  output  4  memory write mask.
REQ-017 dmwr_req_out  output  1  memory write strobe.
REQ-018 dmrd_req_out  output  1  memory read strobe.
REQ-019 dm_ready_in  input  1  memory accepts the presented access this cycle.
REQ-020 dmdata_in  input  32  read data, valid cycle after read acceptance.

Function
REQ-021 FSM states IDLE, HOLD_CORE, HOLD_DMA; owner selection combinational from state and requests.
REQ-022 IDLE: only core requesting -> core owner; only DMA -> DMA owner; both -> core owner unless starve_cnt == STARVE_LIMIT, then DMA owner.
REQ-023 HOLD_CORE / HOLD_DMA: owner fixed to that port regardless of other requests.
REQ-024 Memory outputs combinationally mirror owner: dmaddr_out/dmdata_out/dmwr_mask_out = owner fields; dmwr_req_out = owner req & wr; dmrd_req_out = owner req & ~wr.
REQ-025 No owner -> dmaddr_out, dmdata_out, dmwr_mask_out, dmwr_req_out, dmrd_req_out all 0.
REQ-026 Grant = owner req & dm_ready_in, same cycle; at most one of core_gnt_out/dma_gnt_out high.
REQ-027 Owner presented with dm_ready_in = 0 -> next state HOLD_<owner>; granted -> next state IDLE.
REQ-028 Zero write mask forwarded unchanged and granted normally.
REQ-029 starve_cnt (4 bit): +1 on core grant while dma_req_in = 1, saturates at STARVE_LIMIT; cleared on DMA grant or any cycle dma_req_in = 0.
REQ-030 Read return: granted read registers rd_pending = 1 and rd_owner; next cycle owner's rvalid_out = 1 for exactly one cycle.
REQ-031 core_rdata_out and dma_rdata_out both = dmdata_in at all times; qualified only by rvalid.
REQ-032 Back-to-back accepts each cycle supported: read return of cycle N coexists with grant in N+1 at full throughput.
REQ-033 Requester deasserting req while in HOLD_x -> FSM returns to IDLE next cycle, no grant.

Reset
REQ-034 rst_in = 1 at a clock edge -> state IDLE, starve_cnt 0, rd_pending 0.
REQ-035 During and after reset: grants, rvalids, memory strobes, dmaddr_out/dmdata_out/dmwr_mask_out = 0 until a request appears after rst_in falls.
REQ-036 Reset in cycle after accepted read -> rvalid_out not asserted; return discarded.

Verification
REQ-037 Core store addr 0x0000_1004, wdata 0x00AB_0000, mask 0x4, dm_ready_in = 1 -> same-cycle core_gnt_out, dmwr_req_out = 1, outputs mirror inputs.
REQ-038 DMA read 0x2000 with dm_ready_in = 0 for 3 cycles, then core requests -> outputs remain DMA 0x2000 (HOLD_DMA) until ready; dma_gnt_out, next cycle dma_rvalid_out with dmdata_in 0xDEADBEEF.
REQ-039 Both request continuously, ready = 1, STARVE_LIMIT = 4 -> grant pattern C,C,C,C,D repeating.
REQ-040 Core reads on 3 consecutive cycles, ready = 1 -> core_rvalid_out high 3 cycles, each one cycle after its grant, data ordered.
REQ-041 Read granted cycle N, rst_in = 1 cycle N+1 -> no rvalid in N+1; all outputs 0.
REQ-042 Core request in HOLD_CORE withdrawn before ready -> no grant, IDLE next cycle, strobes 0.
